// File: rtl/clip_ctrl_pkg.sv
// Shared types and default widths for the two-clip record/playback controller.
package clip_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int PTR_W_DEF  = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;
endpackage

// File: rtl/clip_controller_if.sv
// Sample RAM port: address {clip, pointer}, write strobe/data, synchronous read data.
interface clip_controller_if
  import clip_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = PTR_W_DEF
);
  logic [PTR_W:0]    mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/clip_ptr.sv
// Clearable sample pointer with count enable; tc flags the pointer sitting on term.
module clip_ptr #(
  parameter int PTR_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PTR_W-1:0] term,
  output logic [PTR_W-1:0] cnt,
  output logic             tc
);
  logic [PTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);
endmodule

// File: rtl/clip_controller.sv
// Two-clip looper controller: records mic samples into RAM and plays them back
// through a two-stage read pipeline (address, RAM latency, output register).
module clip_controller
  import clip_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pulse,
  input  logic              record_pulse,
  input  logic              clip_play_pulse,
  input  logic              clip_record_pulse,
  input  logic              clear_pulse,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] mic_sample,
  clip_controller_if.master mem,
  output logic [DATA_W-1:0] audio_out,
  output logic              audio_valid,
  output logic [1:0]        state_o,
  output logic              play_clip,
  output logic              rec_clip
);
  state_t                 state_q, state_d;
  logic [1:0][PTR_W:0]    len_q, len_d;
  logic                   play_clip_q, play_clip_d, rec_clip_q, rec_clip_d;
  logic                   play_act_q, play_act_d, rec_act_q, rec_act_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   audio_valid_q, audio_valid_d;
  logic [DATA_W-1:0]      audio_out_q, audio_out_d;

  logic                   w_clr, w_en, w_tc, r_clr, r_en, r_tc;
  logic                   wr_fire, rd_fire;
  logic [PTR_W-1:0]       wptr, rptr, r_term;

  // len of DEPTH has zero low bits, so the wrapped subtraction still gives DEPTH-1
  assign r_term = len_q[play_act_q][PTR_W-1:0] - PTR_W'(1);

  clip_ptr #(.PTR_W(PTR_W)) u_wptr (
    .clk(clk), .rst_n(reset), .clr(w_clr), .en(w_en),
    .term('1), .cnt(wptr), .tc(w_tc)
  );

  clip_ptr #(.PTR_W(PTR_W)) u_rptr (
    .clk(clk), .rst_n(reset), .clr(r_clr), .en(r_en),
    .term(r_term), .cnt(rptr), .tc(r_tc)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    play_clip_d = play_clip_q ^ clip_play_pulse;
    rec_clip_d  = rec_clip_q ^ clip_record_pulse;
    play_act_d  = play_act_q;
    rec_act_d   = rec_act_q;
    w_clr       = 1'b0;
    w_en        = 1'b0;
    r_clr       = 1'b0;
    r_en        = 1'b0;
    wr_fire     = 1'b0;
    rd_fire     = 1'b0;

    if (clear_pulse) begin
      state_d = IDLE;
      len_d   = '0;
      w_clr   = 1'b1;
      r_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (record_pulse) begin
            state_d   = RECORD;
            w_clr     = 1'b1;
            rec_act_d = rec_clip_q;
          end else if (play_pulse && (len_q[play_clip_q] != '0)) begin
            state_d    = PLAY;
            r_clr      = 1'b1;
            play_act_d = play_clip_q;
          end
        end
        RECORD: begin
          if (record_pulse) begin
            state_d          = IDLE;
            len_d[rec_act_q] = {1'b0, wptr};
          end else if (sample_tick) begin
            wr_fire = 1'b1;
            w_en    = 1'b1;
            if (w_tc) begin
              state_d          = IDLE;
              len_d[rec_act_q] = {1'b1, {PTR_W{1'b0}}};
            end
          end
        end
        PLAY: begin
          if (play_pulse) begin
            state_d = IDLE;
          end else if (sample_tick) begin
            rd_fire = 1'b1;
            r_en    = 1'b1;
            if (r_tc) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    rd_pend_d     = rd_fire;
    audio_valid_d = rd_pend_q && !clear_pulse;
    audio_out_d   = audio_valid_d ? mem.mem_rdata : audio_out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      play_clip_q   <= 1'b0;
      rec_clip_q    <= 1'b0;
      play_act_q    <= 1'b0;
      rec_act_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      audio_valid_q <= 1'b0;
      audio_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      play_clip_q   <= play_clip_d;
      rec_clip_q    <= rec_clip_d;
      play_act_q    <= play_act_d;
      rec_act_q     <= rec_act_d;
      rd_pend_q     <= rd_pend_d;
      audio_valid_q <= audio_valid_d;
      audio_out_q   <= audio_out_d;
    end
  end

  assign mem.mem_we    = wr_fire;
  assign mem.mem_wdata = mic_sample;
  assign mem.mem_addr  = (state_q == PLAY) ? {play_act_q, rptr} : {rec_act_q, wptr};

  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign state_o     = state_q;
  assign play_clip   = play_clip_q;
  assign rec_clip    = rec_clip_q;
endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with an 8-deep-per-clip synchronous RAM model.
module tb_clip_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       play_pulse, record_pulse, clip_play_pulse, clip_record_pulse, clear_pulse;
  logic       sample_tick;
  logic [7:0] mic_sample;
  logic [7:0] audio_out;
  logic       audio_valid;
  logic [1:0] state_o;
  logic       play_clip, rec_clip;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] ram [16];

  clip_controller_if #(.DATA_W(8), .PTR_W(3)) mif ();

  clip_controller #(.DATA_W(8), .PTR_W(3)) dut (
    .clk(clk), .reset(reset),
    .play_pulse(play_pulse), .record_pulse(record_pulse),
    .clip_play_pulse(clip_play_pulse), .clip_record_pulse(clip_record_pulse),
    .clear_pulse(clear_pulse), .sample_tick(sample_tick), .mic_sample(mic_sample),
    .mem(mif),
    .audio_out(audio_out), .audio_valid(audio_valid), .state_o(state_o),
    .play_clip(play_clip), .rec_clip(rec_clip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
    mif.mem_rdata <= ram[mif.mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    play_pulse = 0; record_pulse = 0; clip_play_pulse = 0; clip_record_pulse = 0;
    clear_pulse = 0; sample_tick = 0; mic_sample = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    cyc(); cyc();
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    vectors++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", audio_valid); end
    vectors++; if (audio_out !== 8'h00) begin errors++; $display("FAIL reset_audio: got %h expected 00", audio_out); end
    vectors++; if (mif.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", mif.mem_we); end
    vectors++; if ({play_clip, rec_clip} !== 2'b00) begin errors++; $display("FAIL reset_clips: got %b expected 00", {play_clip, rec_clip}); end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_record();
    logic [7:0] smp [3];
    smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33;
    record_pulse = 1; cyc(); record_pulse = 0;
    vectors++; if (state_o !== 2'd1) begin errors++; $display("FAIL rec_start: got %0d expected 1", state_o); end
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1; mic_sample = smp[i]; #1;
      vectors++;
      if ({mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {1'b1, 4'(i), smp[i]}) begin
        errors++;
        $display("FAIL rec_write%0d: got we=%b addr=%h data=%h expected we=1 addr=%h data=%h",
                 i, mif.mem_we, mif.mem_addr, mif.mem_wdata, 4'(i), smp[i]);
      end
      cyc();
    end
    // stop with a coincident tick: no write may occur
    record_pulse = 1; sample_tick = 1; mic_sample = 8'h99; #1;
    vectors++; if (mif.mem_we !== 1'b0) begin errors++; $display("FAIL rec_stop_we: got %b expected 0", mif.mem_we); end
    cyc(); record_pulse = 0; sample_tick = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL rec_stop_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_play();
    logic [7:0] smp [3];
    smp[0] = 8'h11; smp[1] = 8'h22; smp[2] = 8'h33;
    play_pulse = 1; cyc(); play_pulse = 0;
    vectors++; if (state_o !== 2'd2) begin errors++; $display("FAIL play_start: got %0d expected 2", state_o); end
    for (int i = 0; i < 3; i++) begin
      sample_tick = 1; #1;
      vectors++; if (mif.mem_addr !== 4'(i)) begin errors++; $display("FAIL play_addr%0d: got %h expected %h", i, mif.mem_addr, 4'(i)); end
      cyc(); sample_tick = 0;
      vectors++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL play_early%0d: got %b expected 0", i, audio_valid); end
      vectors++; if (state_o !== ((i == 2) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL play_state%0d: got %0d", i, state_o); end
      cyc();
      vectors++;
      if ({audio_valid, audio_out} !== {1'b1, smp[i]}) begin
        errors++; $display("FAIL play_out%0d: got v=%b d=%h expected v=1 d=%h", i, audio_valid, audio_out, smp[i]);
      end
    end
    cyc();
    vectors++;
    if ({audio_valid, audio_out} !== {1'b0, 8'h33}) begin
      errors++; $display("FAIL play_hold: got v=%b d=%h expected v=0 d=33", audio_valid, audio_out);
    end
  endtask

  task automatic test_back_to_back();
    clip_record_pulse = 1; cyc(); clip_record_pulse = 0;
    vectors++; if (rec_clip !== 1'b1) begin errors++; $display("FAIL sel_rec: got %b expected 1", rec_clip); end
    record_pulse = 1; cyc(); record_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      sample_tick = 1; mic_sample = 8'h40 + 8'(i); #1;
      vectors++;
      if (i < 8) begin
        if ({mif.mem_we, mif.mem_addr} !== {1'b1, 4'(8 + i)}) begin
          errors++; $display("FAIL full_write%0d: got we=%b addr=%h expected we=1 addr=%h", i, mif.mem_we, mif.mem_addr, 4'(8 + i));
        end
      end else if (mif.mem_we !== 1'b0) begin
        errors++; $display("FAIL full_nowrite%0d: got we=%b expected 0", i, mif.mem_we);
      end
      cyc();
    end
    sample_tick = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL full_state: got %0d expected 0", state_o); end
    clip_play_pulse = 1; cyc(); clip_play_pulse = 0;
    vectors++; if (play_clip !== 1'b1) begin errors++; $display("FAIL sel_play: got %b expected 1", play_clip); end
    play_pulse = 1; cyc(); play_pulse = 0;
    for (int i = 0; i < 10; i++) begin
      sample_tick = (i < 8);
      cyc();
      vectors++;
      if (i >= 1 && i <= 8) begin
        if ({audio_valid, audio_out} !== {1'b1, 8'h40 + 8'(i - 1)}) begin
          errors++; $display("FAIL b2b_out%0d: got v=%b d=%h expected v=1 d=%h", i, audio_valid, audio_out, 8'h40 + 8'(i - 1));
        end
      end else if (audio_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_idle%0d: got v=%b expected 0", i, audio_valid);
      end
    end
    sample_tick = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL b2b_end: got %0d expected 0", state_o); end
  endtask

  task automatic test_empty_play();
    clear_pulse = 1; cyc(); clear_pulse = 0;
    play_pulse = 1; cyc(); play_pulse = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL empty_state: got %0d expected 0", state_o); end
    sample_tick = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if ({state_o, audio_valid} !== 3'b000) begin
        errors++; $display("FAIL empty_quiet%0d: got st=%0d v=%b expected st=0 v=0", i, state_o, audio_valid);
      end
    end
    sample_tick = 0;
  endtask

  task automatic test_priority_clear();
    play_pulse = 1; record_pulse = 1; cyc(); play_pulse = 0; record_pulse = 0;
    vectors++; if (state_o !== 2'd1) begin errors++; $display("FAIL both_pulses: got %0d expected 1", state_o); end
    play_pulse = 1; cyc(); play_pulse = 0;
    vectors++; if (state_o !== 2'd1) begin errors++; $display("FAIL play_in_rec: got %0d expected 1", state_o); end
    for (int i = 0; i < 2; i++) begin
      sample_tick = 1; mic_sample = 8'hA1 + 8'(i); #1;
      vectors++; if (mif.mem_addr !== 4'(8 + i)) begin errors++; $display("FAIL pri_addr%0d: got %h expected %h", i, mif.mem_addr, 4'(8 + i)); end
      cyc();
    end
    sample_tick = 0;
    record_pulse = 1; cyc(); record_pulse = 0;
    play_pulse = 1; cyc(); play_pulse = 0;
    vectors++; if (state_o !== 2'd2) begin errors++; $display("FAIL pri_play: got %0d expected 2", state_o); end
    sample_tick = 1; clear_pulse = 1; cyc(); sample_tick = 0; clear_pulse = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL clear_state: got %0d expected 0", state_o); end
    for (int i = 0; i < 3; i++) begin
      vectors++; if (audio_valid !== 1'b0) begin errors++; $display("FAIL clear_valid%0d: got %b expected 0", i, audio_valid); end
      cyc();
    end
    vectors++; if ({play_clip, rec_clip} !== 2'b11) begin errors++; $display("FAIL clear_sel: got %b expected 11", {play_clip, rec_clip}); end
    play_pulse = 1; cyc(); play_pulse = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL clear_len: got %0d expected 0", state_o); end
  endtask

  task automatic test_async_reset();
    clip_record_pulse = 1; cyc(); clip_record_pulse = 0;
    record_pulse = 1; cyc(); record_pulse = 0;
    for (int i = 0; i < 2; i++) begin
      sample_tick = 1; mic_sample = 8'h55; cyc();
    end
    #1;
    vectors++; if (mif.mem_we !== 1'b1) begin errors++; $display("FAIL ar_pre_we: got %b expected 1", mif.mem_we); end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if ({state_o, mif.mem_we, audio_out} !== {2'd0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL ar_abort: got st=%0d we=%b d=%h expected st=0 we=0 d=00", state_o, mif.mem_we, audio_out);
    end
    sample_tick = 0;
    cyc(); reset = 1'b1; cyc();
    play_pulse = 1; cyc(); play_pulse = 0;
    vectors++; if (state_o !== 2'd0) begin errors++; $display("FAIL ar_len_lost: got %0d expected 0", state_o); end
  endtask

  initial begin
    test_reset();
    test_record();
    test_play();
    test_back_to_back();
    test_empty_play();
    test_priority_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/clip_controller.md
CLIP_CONTROLLER -- requirements
Module: clip_controller

Interface
REQ-001 Parameter DATA_W, default 8, audio sample width.
REQ-002 Parameter PTR_W, default 14, per-clip sample pointer width; clip depth DEPTH = 2**PTR_W.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 play_pulse, record_pulse, clip_play_pulse, clip_record_pulse, clear_pulse  in  1 each  single-cycle, already-synchronised button pulses.
REQ-006 sample_tick  in  1  one-cycle sample-rate strobe.
REQ-007 mic_sample  in  DATA_W  sample to record, valid when sample_tick=1.
REQ-008 mem_addr  out  PTR_W+1  RAM address {clip bit, pointer}, combinational mux of active pointer.
REQ-009 mem_we  out  1  write strobe; mem_wdata  out  DATA_W  write data.
REQ-010 mem_rdata  in  DATA_W  synchronous RAM read data, valid one cycle after address.
REQ-011 audio_out  out  DATA_W  registered playback sample; audio_valid  out  1  one-cycle strobe.
REQ-012 state_o  out  2  current state; play_clip, rec_clip  out  1 each  selected clips.

Function
REQ-013 States IDLE(0), RECORD(1), PLAY(2); encoding 3 unused, decodes to IDLE next cycle.
REQ-014 clip_record_pulse toggles rec_clip, clip_play_pulse toggles play_clip, in any state; a new selection takes effect only at the next start of the respective operation.
REQ-015 IDLE + record_pulse -> RECORD next cycle, write pointer cleared to 0.
REQ-016 RECORD + sample_tick: mem_we=1 same cycle, mem_addr={rec_clip,wptr}, mem_wdata=mic_sample, wptr increments at edge.
REQ-017 RECORD + record_pulse -> IDLE, len[rec_clip] <= wptr (samples written); no write that cycle even if sample_tick=1.
REQ-018 Write at wptr=DEPTH-1 -> IDLE next cycle, len[rec_clip] <= DEPTH (len registers PTR_W+1 bits); no wrap.
REQ-019 IDLE + play_pulse -> PLAY with rptr=0 only if len[play_clip]!=0; otherwise stay IDLE.
REQ-020 PLAY + sample_tick in cycle T: mem_addr={play_clip,rptr}, rptr increments; audio_out <= mem_rdata at end of T+1; audio_valid=1 in cycle T+2 only.
REQ-021 Tick at rptr=len[play_clip]-1 -> IDLE next cycle; its pending audio_valid is still emitted.
REQ-022 PLAY + play_pulse -> IDLE, no read issued that cycle; already-issued read still completes.
REQ-023 play_pulse in RECORD and record_pulse in PLAY ignored.
REQ-024 play_pulse and record_pulse together in IDLE: record wins.
REQ-025 clear_pulse, highest priority in any state: -> IDLE, both len and both pointers zeroed, pending audio_valid cancelled; clip selects kept.
REQ-026 mem_we=0 outside RECORD; audio_out holds last value between strobes.

Reset
REQ-027 reset low: state IDLE, pointers 0, len[0]=len[1]=0, play_clip=rec_clip=0, audio_out=0, audio_valid=0, mem_we=0, read pipeline cleared.
REQ-028 reset asserted mid-record or mid-play aborts immediately; recorded length of the interrupted clip is lost (0).

Structure
REQ-029 Package clip_ctrl_pkg holds state enum (IDLE/RECORD/PLAY) and default DATA_W/PTR_W constants.
REQ-030 One sub-module clip_ptr: PTR_W-bit clearable counter with enable and terminal-count compare, instantiated for wptr and rptr.

Verification (bench PTR_W=3, DEPTH=8)
REQ-031 record_pulse, 3 ticks with mic 0x11,0x22,0x33, record_pulse -> writes at addr 0,1,2, len[0]=3, state IDLE.
REQ-032 play_pulse after REQ-031 -> audio_valid 3 times, audio_out 0x11,0x22,0x33, each 2 cycles after its tick, then IDLE.
REQ-033 rec_clip=1, record 10 ticks -> 8 writes at addr 8..15, auto-stop, len[1]=8, ticks 9-10 write nothing.
REQ-034 play_pulse with len[play_clip]=0 -> state stays IDLE, no reads, no audio_valid.
REQ-035 play_pulse+record_pulse same cycle in IDLE -> RECORD; clear_pulse during PLAY tick -> IDLE next cycle, no audio_valid, len both 0.
REQ-036 reset low mid-RECORD after 2 writes -> state IDLE, len[0]=0, mem_we=0 immediately (asynchronous).
